// File: rtl/vend_core_param.sv
// Parametrised vending-machine controller: table-driven prices, auto-vend, greedy change output.
// Optional feature macro VEND_TIMEOUT_EN: inactivity refund after TIMEOUT_CYC cycles in COLLECT.
module vend_core_param #(
  parameter int                   CW          = 8,
  parameter int                   N_PROD      = 4,
  parameter logic [N_PROD*CW-1:0] PRICE_TABLE = {8'd15, 8'd12, 8'd10, 8'd8},
  parameter int                   N_COIN      = 3,
  parameter logic [N_COIN*CW-1:0] COIN_VAL    = {8'd10, 8'd5, 8'd2},
  parameter int                   N_CHG       = 4,
  parameter logic [N_CHG*CW-1:0]  CHG_VAL     = {8'd10, 8'd5, 8'd2, 8'd1},
  parameter int                   CREDIT_MAX  = 20,
  parameter int                   CHG_GAP     = 2,
  parameter int                   TIMEOUT_CYC = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_COIN-1:0]         coin_in,
  input  logic [N_PROD-1:0]         sel,
  input  logic                      cancel,
  output logic [CW-1:0]             credit,
  output logic                      dispense,
  output logic [$clog2(N_PROD)-1:0] prod_id,
  output logic [N_CHG-1:0]          chg_pulse,
  output logic                      busy,
  output logic                      coin_rej,
  output logic                      sel_err,
  output logic                      timeout
);
  localparam int          PW   = $clog2(N_PROD);
  localparam int          GW   = $clog2(CHG_GAP + 2);
  localparam logic [CW:0] CMAX = (CW+1)'(CREDIT_MAX);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  function automatic logic [CW-1:0] price_of(input int idx);
    return PRICE_TABLE[idx*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] coin_of(input int idx);
    return COIN_VAL[idx*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] chg_of(input int idx);
    return CHG_VAL[idx*CW +: CW];
  endfunction

  state_t            state;
  logic [N_COIN-1:0] coin_q;
  logic              cancel_q;
  logic [CW-1:0]     rem;
  logic [CW-1:0]     vend_price;
  logic [GW-1:0]     gap;

  logic [N_COIN-1:0] coin_ev;
  logic              cancel_ev;
  int                n_coin, coin_idx, n_sel, sel_idx, chg_idx;
  logic [CW-1:0]     coin_val, price, chg_val;
  logic [CW:0]       sum;
  logic              over, vend_go, to_hit;
  logic [N_CHG-1:0]  chg_oh;

  assign coin_ev   = coin_in & ~coin_q;
  assign cancel_ev = cancel & ~cancel_q;

  always_comb begin
    n_coin   = 0;
    coin_idx = 0;
    for (int i = 0; i < N_COIN; i++)
      if (coin_ev[i]) begin
        n_coin   = n_coin + 1;
        coin_idx = i;
      end
    n_sel   = 0;
    sel_idx = 0;
    for (int i = 0; i < N_PROD; i++)
      if (sel[i]) begin
        n_sel   = n_sel + 1;
        sel_idx = i;
      end
    // denominations ascend, so the last one that fits is the largest
    chg_idx = 0;
    for (int j = 0; j < N_CHG; j++)
      if (chg_of(j) <= rem) chg_idx = j;
    coin_val        = coin_of(coin_idx);
    price           = price_of(sel_idx);
    chg_val         = chg_of(chg_idx);
    chg_oh          = '0;
    chg_oh[chg_idx] = 1'b1;
    sum             = {1'b0, credit} + {1'b0, coin_val};
    over            = sum > CMAX;
    vend_go         = (state == COLLECT) && (n_sel == 1) && (credit >= price);
  end

  assign sel_err = (credit != '0) && (n_sel != 1);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [N_PROD-1:0] sel_q;
  logic [TW-1:0]     to_cnt;
  logic              activity;

  assign activity = (|coin_ev) || cancel_ev || (sel != sel_q);
  assign to_hit   = (state == COLLECT) && !activity && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      to_cnt <= '0;
    end else begin
      sel_q <= sel;
      if (state != COLLECT || activity) to_cnt <= '0;
      else                              to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      coin_q     <= '0;
      cancel_q   <= 1'b0;
      credit     <= '0;
      rem        <= '0;
      vend_price <= '0;
      gap        <= '0;
      dispense   <= 1'b0;
      prod_id    <= '0;
      chg_pulse  <= '0;
      busy       <= 1'b0;
      coin_rej   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      coin_q    <= coin_in;
      cancel_q  <= cancel;
      dispense  <= 1'b0;
      chg_pulse <= '0;
      coin_rej  <= 1'b0;
      timeout   <= 1'b0;
      unique case (state)
        IDLE, COLLECT: begin
          // priority: vend, then cancel/timeout refund, then coin acceptance
          if (vend_go) begin
            state      <= DISPENSE;
            busy       <= 1'b1;
            dispense   <= 1'b1;
            prod_id    <= PW'(sel_idx);
            vend_price <= price;
            coin_rej   <= |coin_ev;
          end else if ((cancel_ev && state == COLLECT) || to_hit) begin
            state    <= CHANGE;
            busy     <= 1'b1;
            rem      <= credit;
            credit   <= '0;
            gap      <= '0;
            timeout  <= to_hit;
            coin_rej <= |coin_ev;
          end else if (|coin_ev) begin
            coin_rej <= (n_coin > 1) || over;
            if (!over) begin
              credit <= sum[CW-1:0];
              state  <= COLLECT;
            end
          end
        end
        DISPENSE: begin
          credit   <= '0;
          rem      <= credit - vend_price;
          gap      <= '0;
          coin_rej <= |coin_ev;
          if (credit == vend_price) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CHANGE;
          end
        end
        CHANGE: begin
          coin_rej <= |coin_ev;
          if (gap != '0) begin
            gap <= gap - GW'(1);
          end else if (rem != '0) begin
            chg_pulse <= chg_oh;
            rem       <= rem - chg_val;
            gap       <= GW'(CHG_GAP);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_core_param.sv
// Directed bench for vend_core_param with a transaction-level reference model and per-cycle compare.
module tb_vend_core_param;
  localparam int CHG_GAP     = 2;
  localparam int TIMEOUT_CYC = 100;
  localparam int CMAX        = 20;
  localparam int PRICE[4]    = '{8, 10, 12, 15};
  localparam int COINV[3]    = '{2, 5, 10};
  localparam int CHGV[4]     = '{1, 2, 5, 10};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] coin_in;
  logic [3:0] sel;
  logic       cancel;
  logic [7:0] credit;
  logic       dispense;
  logic [1:0] prod_id;
  logic [3:0] chg_pulse;
  logic       busy, coin_rej, sel_err, timeout;

  vend_core_param dut (
    .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .sel(sel), .cancel(cancel),
    .credit(credit), .dispense(dispense), .prod_id(prod_id), .chg_pulse(chg_pulse),
    .busy(busy), .coin_rej(coin_rej), .sel_err(sel_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one record per visible output cycle ----------------
  typedef struct {
    bit         busy;
    bit         disp;
    int         pid;
    logic [3:0] pulse;
    int         cr;
    bit         to;
  } rec_t;

  rec_t       sched[$];
  rec_t       cur;
  int         m_credit;
  logic [2:0] m_coin_prev;
  bit         m_cancel_prev;
  logic [3:0] m_sel_prev;
  bit         m_rej;
  int         m_to_cnt;

  function automatic rec_t mk(bit b, bit d, int p, logic [3:0] pl, int c, bit t);
    rec_t r;
    r.busy = b; r.disp = d; r.pid = p; r.pulse = pl; r.cr = c; r.to = t;
    return r;
  endfunction

  // greedy payout: each coin is one pulse cycle followed by CHG_GAP quiet busy cycles
  function automatic void add_change(input int amt);
    int a = amt;
    for (int d = 3; d >= 0; d--)
      while (a >= CHGV[d]) begin
        a -= CHGV[d];
        sched.push_back(mk(1, 0, 0, 4'(1 << d), 0, 0));
        for (int g = 0; g < CHG_GAP; g++) sched.push_back(mk(1, 0, 0, 4'b0, 0, 0));
      end
  endfunction

  logic [2:0] m_cev;
  bit         m_kev, m_act, m_fire_to;
  int         m_pi, m_hi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_credit = 0; sched.delete(); cur = mk(0, 0, 0, 4'b0, 0, 0);
      m_coin_prev = '0; m_cancel_prev = 0; m_sel_prev = '0; m_rej = 0; m_to_cnt = 0;
    end else begin
      m_cev = coin_in & ~m_coin_prev;
      m_kev = cancel && !m_cancel_prev;
      m_act = (m_cev != 0) || m_kev || (sel != m_sel_prev);
      m_coin_prev = coin_in; m_cancel_prev = cancel; m_sel_prev = sel;
      m_rej = 0;
      m_fire_to = 0;
      if (cur.busy) begin
        m_rej = (m_cev != 0);
        m_to_cnt = 0;
        cur = (sched.size() > 0) ? sched.pop_front() : mk(0, 0, 0, 4'b0, m_credit, 0);
      end else begin
        m_pi = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) m_pi = i;
`ifdef VEND_TIMEOUT_EN
        if (m_credit > 0 && !m_act) begin
          if (m_to_cnt == TIMEOUT_CYC - 1) m_fire_to = 1;
          m_to_cnt++;
        end else m_to_cnt = 0;
`endif
        if (m_credit > 0 && $countones(sel) == 1 && m_credit >= PRICE[m_pi]) begin
          sched.push_back(mk(1, 1, m_pi, 4'b0, m_credit, 0));
          if (m_credit > PRICE[m_pi]) begin
            sched.push_back(mk(1, 0, 0, 4'b0, 0, 0));
            add_change(m_credit - PRICE[m_pi]);
          end
          m_credit = 0; m_rej = (m_cev != 0); cur = sched.pop_front();
        end else if (m_credit > 0 && (m_kev || m_fire_to)) begin
          sched.push_back(mk(1, 0, 0, 4'b0, 0, m_fire_to));
          add_change(m_credit);
          m_credit = 0; m_rej = (m_cev != 0); cur = sched.pop_front();
        end else begin
          if (m_cev != 0) begin
            m_hi = 0;
            for (int i = 0; i < 3; i++) if (m_cev[i]) m_hi = i;
            if ($countones(m_cev) > 1) m_rej = 1;
            if (m_credit + COINV[m_hi] > CMAX) m_rej = 1;
            else m_credit += COINV[m_hi];
          end
          cur = mk(0, 0, 0, 4'b0, m_credit, 0);
        end
      end
    end
  end

  // ---------------- per-cycle compare and event logs ----------------
  int         cyc = 0;
  int         disp_log[$];
  logic [3:0] pul_log[$];
  int         pul_cyc[$];
  int         to_n = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("credit", credit, cur.cr);
      chk("dispense", dispense, cur.disp);
      if (cur.disp) chk("prod_id", prod_id, cur.pid);
      chk("chg_pulse", chg_pulse, cur.pulse);
      chk("busy", busy, cur.busy);
      chk("coin_rej", coin_rej, m_rej);
      chk("sel_err", sel_err, (cur.cr != 0) && ($countones(sel) != 1));
      chk("timeout", timeout, cur.to);
      if (dispense) disp_log.push_back(int'(prod_id));
      if (chg_pulse != 0) begin
        pul_log.push_back(chg_pulse);
        pul_cyc.push_back(cyc);
      end
      if (timeout) to_n++;
    end
  end

  function automatic logic [31:0] pulses_packed();
    logic [31:0] v = '0;
    foreach (pul_log[i]) v = (v << 4) | 32'(pul_log[i]);
    return v;
  endfunction

  function automatic logic [31:0] disp_packed();
    logic [31:0] v = '0;
    foreach (disp_log[i]) v = (v << 4) | 32'(disp_log[i] + 1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    disp_log.delete(); pul_log.delete(); pul_cyc.delete();
  endtask

  task automatic put_coin(input string nm, input int idx, input int exp_cr, input bit exp_rej);
    coin_in[idx] = 1'b1;
    tick();
    chk({nm, "_credit"}, credit, exp_cr);
    chk({nm, "_rej"}, coin_rej, exp_rej);
    coin_in = '0;
    tick();
  endtask

  task automatic press_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    repeat (3) tick();
    while ((busy || dispense) && n < 100) begin
      tick();
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; coin_in = '0; sel = '0; cancel = 1'b0;
    repeat (3) tick();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_prod_id", prod_id, 0);
    chk("rst_chg", chg_pulse, 0);
    chk("rst_rej_to", {coin_rej, timeout, sel_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // price 12: 2+5+10=17, vend idx2, change 5
    clear_logs(); sel = 4'b0100;
    put_coin("t1c0", 0, 2, 0);
    put_coin("t1c1", 1, 7, 0);
    put_coin("t1c2", 2, 17, 0);
    wait_idle("t1_idle");
    chk("t1_disp", disp_packed(), 32'h3);
    chk("t1_pulses", pulses_packed(), 32'h4);
    chk("t1_credit", credit, 0);

    // price 8 from a single 10, change 2
    clear_logs(); sel = 4'b0001;
    put_coin("t2c", 2, 10, 0);
    wait_idle("t2_idle");
    chk("t2_disp", disp_packed(), 32'h1);
    chk("t2_pulses", pulses_packed(), 32'h2);

    // cancel refund of 7: 5 then 2, CHG_GAP quiet cycles between
    clear_logs(); sel = 4'b0000;
    put_coin("t3c0", 0, 2, 0);
    put_coin("t3c1", 1, 7, 0);
    press_cancel();
    wait_idle("t3_idle");
    chk("t3_disp", disp_packed(), 32'h0);
    chk("t3_pulses", pulses_packed(), 32'h42);
    chk("t3_spacing", (pul_cyc.size() == 2) ? pul_cyc[1] - pul_cyc[0] : -1, CHG_GAP + 1);
    chk("t3_credit", credit, 0);

    // credit ceiling, then invalid and valid selections
    clear_logs();
    put_coin("t4c0", 2, 10, 0);
    put_coin("t4c1", 2, 20, 0);
    put_coin("t4c2", 1, 20, 1);
    sel = 4'b0101;
    repeat (2) tick();
    chk("t5_sel_err", sel_err, 1);
    chk("t5_nodisp", disp_packed(), 32'h0);
    sel = 4'b1000;
    wait_idle("t5_idle");
    chk("t5_disp", disp_packed(), 32'h4);
    chk("t5_pulses", pulses_packed(), 32'h4);

    // two coins at once (5 kept), exact vend, coin during DISPENSE refused
    clear_logs(); sel = 4'b0000;
    coin_in = 3'b011;
    tick();
    chk("t6_multi_credit", credit, 5);
    chk("t6_multi_rej", coin_rej, 1);
    coin_in = '0;
    tick();
    sel = 4'b0010;
    put_coin("t6c", 1, 10, 0);
    coin_in[0] = 1'b1;
    tick();
    chk("t6_busy_rej", coin_rej, 1);
    chk("t6_busy_credit", credit, 0);
    coin_in = '0;
    wait_idle("t6_idle");
    chk("t6_disp", disp_packed(), 32'h2);
    chk("t6_pulses", pulses_packed(), 32'h0);

    // change of 12 split 10 + 2
    clear_logs(); sel = 4'b0000;
    put_coin("t7c0", 2, 10, 0);
    put_coin("t7c1", 2, 20, 0);
    sel = 4'b0001;
    wait_idle("t7_idle");
    chk("t7_disp", disp_packed(), 32'h1);
    chk("t7_pulses", pulses_packed(), 32'h82);

    // cancel together with a satisfied selection: vend wins
    clear_logs(); sel = 4'b0000;
    put_coin("t8c", 2, 10, 0);
    sel = 4'b0010; cancel = 1'b1;
    tick();
    cancel = 1'b0;
    wait_idle("t8_idle");
    chk("t8_disp", disp_packed(), 32'h2);
    chk("t8_pulses", pulses_packed(), 32'h0);

    // cancel together with a coin: coin refused, 5 refunded
    clear_logs(); sel = 4'b0000;
    put_coin("t9c", 1, 5, 0);
    coin_in[0] = 1'b1; cancel = 1'b1;
    tick();
    chk("t9_rej", coin_rej, 1);
    chk("t9_credit", credit, 0);
    coin_in = '0; cancel = 1'b0;
    wait_idle("t9_idle");
    chk("t9_pulses", pulses_packed(), 32'h4);
    chk("t9_disp", disp_packed(), 32'h0);

    // reset while paying change drops the rest of the refund
    clear_logs();
    put_coin("t10c0", 2, 10, 0);
    put_coin("t10c1", 2, 20, 0);
    press_cancel();
    n = 0;
    while (chg_pulse == 0 && n < 20) begin
      tick();
      n++;
    end
    chk("t10_first_pulse", chg_pulse, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("t10_rst_out", {credit, dispense, chg_pulse, busy, coin_rej, timeout, prod_id}, 0);
    tick();
    clear_logs();
    @(negedge clk) rst_n = 1'b1;
    repeat (8) tick();
    chk("t10_after_pulses", pulses_packed(), 32'h0);
    chk("t10_after_credit", credit, 0);

`ifdef VEND_TIMEOUT_EN
    // inactivity refund
    clear_logs(); to_n = 0; sel = 4'b0000;
    put_coin("t11c", 1, 5, 0);
    repeat (TIMEOUT_CYC + 5) tick();
    wait_idle("t11_idle");
    chk("t11_timeouts", to_n, 1);
    chk("t11_pulses", pulses_packed(), 32'h4);
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
